reorder_buffer: RTL and testbench

//  In-order retirement queue for the out-of-order core. Dispatch allocates one entry per

---
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 tb/tb_reorder_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue for the out-of-order core.
// Dispatch allocates entries at the tail and receives the tail index as the
// instruction's tag. Execution units post results by tag in any order. Entries
// retire from the head in program order. Each retirement drives the
// register-file write port. A retiring mispredicted branch empties the whole
// buffer one edge later and raises a one-cycle mispred flush pulse.
module reorder_buffer #(
    parameter int DEPTH  = 64,
    parameter int TAG_W  = 6,
    parameter int REG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    input  logic [DATA_W-1:0] cmpl_data,
    input  logic              cmpl_mispred,
    output logic              we,
    output logic [REG_W-1:0]  write_reg,
    output logic [TAG_W-1:0]  write_tag,
    output logic [DATA_W-1:0] write_data,
    output logic              mispred,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    // Per-entry status bits are flat vectors so they can be cleared in one step.
    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_mp;
    logic [REG_W-1:0]  ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic              flush_pending;

    logic              blocked;
    logic              do_alloc;
    logic              do_cmpl;
    logic              do_commit;

    assign alloc_tag = tail;

    // Decode this cycle's allocate / complete / commit events from registered state.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        blocked     = 1'b0;
        alloc_ready = 1'b0;
        do_alloc    = 1'b0;
        do_cmpl     = 1'b0;
        do_commit   = 1'b0;

        blocked     = flush_pending || mispred;
        alloc_ready = (count < FULL_COUNT) && !blocked;
        do_alloc    = alloc_valid && alloc_ready;
        do_cmpl     = cmpl_valid && ent_valid[cmpl_tag] && !blocked;
        do_commit   = ent_valid[head] && ent_done[head] && !blocked;
    end

    // Payload storage: destination register on allocate, result on completion.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays have no reset; an entry's valid bit qualifies every read of them.
        if (do_alloc) begin
            ent_rd[tail] <= alloc_rd;
        end
        if (do_cmpl) begin
            ent_data[cmpl_tag] <= cmpl_data;
        end
    end

    // Entry status, pointers, occupancy, retirement port and flush sequencing.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments, so every read in this block sees the pre-edge value.
        if (reset) begin
            ent_valid     <= '0;
            ent_done      <= '0;
            ent_mp        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            we            <= 1'b0;
            mispred       <= 1'b0;
            write_reg     <= '0;
            write_tag     <= '0;
            write_data    <= '0;
        end else if (flush_pending) begin
            // The mispredicted branch retired last edge: drop every younger entry.
            ent_valid     <= '0;
            ent_done      <= '0;
            ent_mp        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            we            <= 1'b0;
            mispred       <= 1'b1;
        end else begin
            mispred <= 1'b0;
            we      <= 1'b0;

            if (do_commit) begin
                we              <= (ent_rd[head] != '0);
                write_reg       <= ent_rd[head];
                write_tag       <= head;
                write_data      <= ent_data[head];
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
                if (ent_mp[head]) begin
                    flush_pending <= 1'b1;
                end
            end

            if (do_cmpl) begin
                ent_done[cmpl_tag] <= 1'b1;
                ent_mp[cmpl_tag]   <= cmpl_mispred;
            end

            // Allocation is last so a fresh entry always starts not-done.
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                ent_mp[tail]    <= 1'b0;
                tail            <= tail + 1'b1;
            end

            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Directed stimulus pushes the expected
// register-file writes and flush pulses into a scoreboard queue. A monitor on
// the falling edge pops and compares each write or flush the DUT presents.
module tb_reorder_buffer;

    localparam int DEPTH  = 64;
    localparam int TAG_W  = 6;
    localparam int REG_W  = 6;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cmpl_valid;
    logic [TAG_W-1:0]  cmpl_tag;
    logic [DATA_W-1:0] cmpl_data;
    logic              cmpl_mispred;
    logic              we;
    logic [REG_W-1:0]  write_reg;
    logic [TAG_W-1:0]  write_tag;
    logic [DATA_W-1:0] write_data;
    logic              mispred;
    logic [TAG_W:0]    count;

    typedef struct {
        bit                flush;
        logic [REG_W-1:0]  rd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   failures = 0;
    int   exp_tail = 0;

    reorder_buffer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .REG_W (REG_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cmpl_valid  (cmpl_valid),
        .cmpl_tag    (cmpl_tag),
        .cmpl_data   (cmpl_data),
        .cmpl_mispred(cmpl_mispred),
        .we          (we),
        .write_reg   (write_reg),
        .write_tag   (write_tag),
        .write_data  (write_data),
        .mispred     (mispred),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int rd, input int tag, input int data);
        exp_t e;
        e.flush = 1'b0;
        e.rd    = REG_W'(rd);
        e.tag   = TAG_W'(tag);
        e.data  = DATA_W'(data);
        sb.push_back(e);
    endtask

    task automatic push_flush();
        exp_t e;
        e.flush = 1'b1;
        e.rd    = '0;
        e.tag   = '0;
        e.data  = '0;
        sb.push_back(e);
    endtask

    // Monitor: every write or flush pulse the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (we || mispred) begin
                check("we_mispred_exclusive", 32'(we & mispred), 32'd0);
            end
            if (we) begin
                if (sb.size() == 0 || sb[0].flush) begin
                    tests++;
                    failures++;
                    $display("FAIL unexpected_write: got reg=%0d tag=%0d data=0x%0h, expected no write (t=%0t)",
                             write_reg, write_tag, write_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("write_reg",  32'(write_reg),  32'(e.rd));
                    check("write_tag",  32'(write_tag),  32'(e.tag));
                    check("write_data", write_data,      e.data);
                end
            end
            if (mispred) begin
                if (sb.size() == 0 || !sb[0].flush) begin
                    tests++;
                    failures++;
                    $display("FAIL unexpected_mispred: got mispred=1, expected 0 (t=%0t)", $time);
                end else begin
                    void'(sb.pop_front());
                    check("flush_blocks_alloc", 32'(alloc_ready), 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_alloc(input int rd);
        check("alloc_ready", 32'(alloc_ready), 32'd1);
        check("alloc_tag",   32'(alloc_tag),   32'(exp_tail));
        alloc_valid = 1'b1;
        alloc_rd    = REG_W'(rd);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        exp_tail    = (exp_tail + 1) % DEPTH;
    endtask

    task automatic do_cmpl(input int tag, input int data, input bit mp);
        cmpl_valid   = 1'b1;
        cmpl_tag     = TAG_W'(tag);
        cmpl_data    = DATA_W'(data);
        cmpl_mispred = mp;
        @(posedge clk);
        #1;
        cmpl_valid   = 1'b0;
        cmpl_mispred = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_tail = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        cmpl_valid   = 1'b0;
        cmpl_tag     = '0;
        cmpl_data    = '0;
        cmpl_mispred = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1. Reset state.
        check("reset_we",          32'(we),          32'd0);
        check("reset_mispred",     32'(mispred),     32'd0);
        check("reset_count",       32'(count),       32'd0);
        check("reset_alloc_tag",   32'(alloc_tag),   32'd0);
        check("reset_alloc_ready", 32'(alloc_ready), 32'd1);

        // 2. Out-of-order completion, in-order retirement.
        do_alloc(5);
        do_alloc(6);
        do_alloc(7);
        check("t2_count", 32'(count), 32'd3);
        push_wr(5, 0, 'h10);
        push_wr(6, 1, 'h20);
        push_wr(7, 2, 'h30);
        do_cmpl(2, 'h30, 1'b0);
        check("t2_no_early_write", 32'(we), 32'd0);
        do_cmpl(0, 'h10, 1'b0);
        do_cmpl(1, 'h20, 1'b0);
        idle(4);
        check("t2_count_empty", 32'(count), 32'd0);

        // 3. Full buffer, ignored extra alloc, wrap of the tail.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) begin
            do_alloc((i % 63) + 1);
        end
        check("t3_count_full", 32'(count),       32'd64);
        check("t3_ready_full", 32'(alloc_ready), 32'd0);
        alloc_valid = 1'b1;
        alloc_rd    = REG_W'(9);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        check("t3_extra_ignored", 32'(count),     32'd64);
        check("t3_tail_wrapped",  32'(alloc_tag), 32'd0);
        push_wr(1, 0, 'hA0);
        do_cmpl(0, 'hA0, 1'b0);
        idle(2);
        check("t3_count_after_retire", 32'(count),       32'd63);
        check("t3_ready_after_retire", 32'(alloc_ready), 32'd1);
        do_alloc(2);
        check("t3_count_refull", 32'(count),     32'd64);
        check("t3_next_tag",     32'(alloc_tag), 32'd1);

        // 4. Mispredicted branch at tag 1 flushes tags 2 and 3.
        pulse_reset();
        do_alloc(1);
        do_alloc(2);
        do_alloc(3);
        do_alloc(4);
        push_wr(1, 0, 'h40);
        push_wr(2, 1, 'h41);
        push_flush();
        do_cmpl(0, 'h40, 1'b0);
        do_cmpl(1, 'h41, 1'b1);
        do_cmpl(2, 'h42, 1'b0);
        do_cmpl(3, 'h43, 1'b0);
        idle(3);
        exp_tail = 0;
        check("t4_count",       32'(count),       32'd0);
        check("t4_alloc_tag",   32'(alloc_tag),   32'd0);
        check("t4_alloc_ready", 32'(alloc_ready), 32'd1);
        check("t4_mispred_low", 32'(mispred),     32'd0);

        // 5. rd = 0 retires without a register write.
        do_alloc(0);
        do_alloc(9);
        push_wr(9, 1, 'h66);
        do_cmpl(0, 'h55, 1'b0);
        do_cmpl(1, 'h66, 1'b0);
        idle(3);
        check("t5_count",     32'(count),     32'd0);
        check("t5_alloc_tag", 32'(alloc_tag), 32'd2);

        // 6. Reset mid-operation discards pending entries.
        for (int i = 0; i < 10; i++) begin
            do_alloc(i + 1);
        end
        for (int i = 7; i < 12; i++) begin
            do_cmpl(i, 'h70 + i, 1'b0);
        end
        idle(2);
        check("t6_count_pending", 32'(count), 32'd10);
        pulse_reset();
        check("t6_count_reset",     32'(count),     32'd0);
        check("t6_we_reset",        32'(we),        32'd0);
        check("t6_mispred_reset",   32'(mispred),   32'd0);
        check("t6_alloc_tag_reset", 32'(alloc_tag), 32'd0);
        idle(4);
        do_alloc(3);
        check("t6_count_after", 32'(count), 32'd1);

        idle(2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
